uart_byte_xcvr: RTL and testbench
=================================

// Module: uart_byte_xcvr
// PURPOSE
//  Byte-level UART transceiver directly upstream of the UART command decoder.
//  Deserialises uart_rxd into bytes, flagged by a short uart_rec pulse that the decoder edge-detects.
//  Serialises bytes requested on rising edges of uart_send; a TX FIFO absorbs back-to-back replies.
//  Frame is 8N1 (8E1 with UART_PARITY_EN), LSB first; line idles high.
// PARAMETERS
//  CLK_FREQ       50_000_000  sys_clk frequency, Hz
//  BAUD           115200      line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide), must be >= 4
//  REC_PULSE      2           uart_rec high time per received byte, cycles (>= 1)
//  TX_FIFO_DEPTH  4           TX FIFO entries; power of 2, >= 2
// PORTS
//  sys_clk        in   1  sole clock
//  sys_rst        in   1  synchronous reset, active-high
//  uart_rxd       in   1  serial in, asynchronous
//  uart_txd       out  1  serial out
//  uart_rec       out  1  high REC_PULSE cycles after each valid byte
//  uart_data_out  out  8  last valid byte; stable until the next valid byte
//  uart_send      in   1  rising edge enqueues uart_data_in
//  uart_data_in   in   8  TX byte, sampled in the cycle uart_send is first seen high
//  tx_busy        out  1  FIFO non-empty or frame in progress
//  tx_full        out  1  FIFO holds TX_FIFO_DEPTH entries
//  rx_err         out  1  1-cycle pulse on framing (or parity) error
//  tx_ovf         out  1  sticky: a send was dropped because the FIFO was full; cleared only by reset
// BEHAVIOUR
//  Reset (sys_rst high at a clock edge): uart_txd=1, uart_rec=0, uart_data_out=0, tx_busy=0,
//   tx_full=0, rx_err=0, tx_ovf=0; FIFO emptied; both FSMs go to IDLE; bit/baud counters cleared.
//   Reset mid-frame aborts the frame: uart_txd is high from the first cycle after the reset edge.
//  RX: uart_rxd passes a 2-flop synchroniser (idle value 1); an RX frame is timed from the synchronised low.
//   IDLE -> START on a synchronised low.
//   START: wait CLKS_PER_BIT/2; low -> DATA, high -> IDLE (glitch, no rx_err).
//   DATA: sample every CLKS_PER_BIT (mid-bit), 8 bits LSB first -> STOP (-> PARITY with macro).
//   STOP: sample at mid-bit. High: uart_data_out updated and uart_rec raised in the same cycle.
//    Low: rx_err pulses, data discarded. Either way -> IDLE immediately, so the next start bit is caught.
//   A new valid byte during the uart_rec pulse restarts the REC_PULSE count; uart_rec stays high.
//  TX enqueue: uart_send_q registered; push when uart_send & ~uart_send_q. Level held high = one push.
//   Push when full: byte dropped, tx_ovf set. Push and pop in the same cycle: occupancy unchanged.
//   Pointers are log2(TX_FIFO_DEPTH) bits wide and wrap naturally; a separate count gives full/empty.
//  TX FSM: IDLE -> START when FIFO non-empty: pop, uart_txd=0.
//   START -> DATA (8 bits LSB first) -> STOP (uart_txd=1) -> IDLE; each bit lasts exactly CLKS_PER_BIT cycles.
//   Next frame may start the cycle after STOP ends. Minimum frame is 10*CLKS_PER_BIT cycles (11 with parity).
//  tx_busy is combinational: (count!=0) | (state!=IDLE). Push-to-first-start-bit latency: 2 cycles.
// CONFIGURATION
//  `UART_PARITY_EN defined: even parity bit after D7 on TX; RX adds a PARITY state after DATA.
//   A parity mismatch gives an rx_err pulse at STOP and the byte is discarded even if the stop bit is good.
//  Not defined: 8N1 only; no parity logic is synthesised.
// TESTING (CLK_FREQ=50_000_000, BAUD=5_000_000 -> 10 clk/bit)
//  Reset: after reset, uart_txd=1, flags=0; RX frame of 0xA5 -> uart_data_out=0xA5, uart_rec high exactly 2 cycles.
//  Back-to-back RX 0x3F,0x44 with no idle gap -> two distinct uart_rec pulses, data 0x3F then 0x44.
//  RX 0x55 with stop bit low -> rx_err single pulse, uart_rec stays 0, uart_data_out unchanged.
//   A 3-cycle low glitch on idle line -> nothing.
//  Five uart_send edges (0x01..0x05) while idle, default depth -> 0x01..0x05 on uart_txd,
//   gap-free 100-cycle frames. A sixth edge while full -> dropped, tx_ovf=1.
//  uart_send held high 50 cycles -> exactly one byte sent. Reset asserted mid-TX bit 3 ->
//   uart_txd=1 the next cycle, FIFO empty, tx_busy=0.
//  With UART_PARITY_EN: TX 0x07 sends parity 1; RX 0x03 with parity 1 -> rx_err, no uart_rec.

Source files
------------

// File: rtl/uart_byte_xcvr.sv
// -----------------------------------------------------------------------------
// uart_byte_xcvr
//   Byte-level UART transceiver feeding the UART command decoder.
//   RX: deserialises uart_rxd into bytes; each valid byte updates uart_data_out
//       and raises uart_rec for REC_PULSE cycles.
//   TX: each rising edge of uart_send queues uart_data_in in a small FIFO; the
//       TX FSM serialises queued bytes back-to-back.
//   Frame: start, 8 data bits LSB first, [even parity], stop. Line idles high.
//   Optional feature macro: UART_PARITY_EN (adds an even parity bit on TX and
//   parity checking on RX). Undefined build is plain 8N1.
// Ports
//   sys_clk        clock
//   sys_rst        synchronous reset, active-high
//   uart_rxd       serial input (asynchronous)
//   uart_txd       serial output
//   uart_rec       high REC_PULSE cycles after each valid received byte
//   uart_data_out  last valid received byte
//   uart_send      rising edge enqueues uart_data_in
//   uart_data_in   byte to transmit
//   tx_busy        FIFO non-empty or frame in progress
//   tx_full        FIFO holds TX_FIFO_DEPTH entries
//   rx_err         1-cycle pulse on framing / parity error
//   tx_ovf         sticky: a send was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_byte_xcvr #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int REC_PULSE     = 2,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       uart_rec,
  output logic [7:0] uart_data_out,
  input  logic       uart_send,
  input  logic [7:0] uart_data_in,
  output logic       tx_busy,
  output logic       tx_full,
  output logic       rx_err,
  output logic       tx_ovf
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int RW = (REC_PULSE > 1) ? $clog2(REC_PULSE) : 1;
  localparam logic [CW-1:0] C_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   C_DEPTH    = (AW+1)'(TX_FIFO_DEPTH);
  localparam logic [RW-1:0] C_REC_LAST = RW'(REC_PULSE - 1);

`ifdef UART_PARITY_EN
  function automatic logic f_even_par(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  // ---------------- RX ----------------
  logic          r_rxd_m, r_rxd_s;
  rx_state_t     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic [RW-1:0] r_rec_cnt;
`ifdef UART_PARITY_EN
  logic          r_rx_par_bad;
`endif

  // Two-flop synchroniser for the asynchronous serial input (idles high).
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rxd_m <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_rxd_m <= uart_rxd;
      r_rxd_s <= r_rxd_m;
    end
  end

  // RX FSM: start detect, mid-bit sampling, byte delivery and uart_rec stretching.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rx_state    <= RX_IDLE;
      r_rx_cnt      <= '0;
      r_rx_bit      <= 3'd0;
      r_rx_shift    <= 8'h00;
      r_rec_cnt     <= '0;
      uart_rec      <= 1'b0;
      uart_data_out <= 8'h00;
      rx_err        <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_bad  <= 1'b0;
`endif
    end else begin
      rx_err <= 1'b0;
      // A new valid byte below overrides this and restarts the pulse.
      if (r_rec_cnt != '0) r_rec_cnt <= r_rec_cnt - 1'b1;
      else                 uart_rec  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (!r_rxd_s) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == C_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            // Line back high at mid start bit: treat as a glitch.
            r_rx_state <= r_rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == C_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rxd_s, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
`ifdef UART_PARITY_EN
            if (r_rx_bit == 3'd7) r_rx_state <= RX_PARITY;
`else
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
`endif
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (r_rx_cnt == C_LAST) begin
            r_rx_cnt     <= '0;
            r_rx_par_bad <= f_even_par(r_rx_shift) ^ r_rxd_s;
            r_rx_state   <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (r_rx_cnt == C_LAST) begin
            // Back to IDLE at mid stop bit so a following start bit is not missed.
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
`ifdef UART_PARITY_EN
            if (r_rxd_s && !r_rx_par_bad) begin
`else
            if (r_rxd_s) begin
`endif
              uart_data_out <= r_rx_shift;
              uart_rec      <= 1'b1;
              r_rec_cnt     <= C_REC_LAST;
            end else begin
              rx_err <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
          r_rx_cnt   <= '0;
        end
      endcase
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    r_fifo [TX_FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_send_q;
  tx_state_t     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
`ifdef UART_PARITY_EN
  logic          r_tx_par;
`endif
  logic          w_push, w_push_ok, w_tx_load;

  assign w_push    = uart_send & ~r_send_q;
  assign tx_full   = (r_count == C_DEPTH);
  assign w_push_ok = w_push & ~tx_full;
  // Pop from IDLE, or straight out of the last STOP cycle for gap-free frames.
  assign w_tx_load = (r_count != '0) &&
                     ((r_tx_state == TX_IDLE) ||
                      ((r_tx_state == TX_STOP) && (r_tx_cnt == C_LAST)));
  assign tx_busy   = (r_count != '0) | (r_tx_state != TX_IDLE);

  // FIFO storage write port (contents need no reset; count qualifies them).
  always_ff @(posedge sys_clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= uart_data_in;
  end

  // FIFO pointers, occupancy, send edge detect and overflow flag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_send_q <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      r_send_q <= uart_send;
      if (w_push_ok)        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_push & tx_full) tx_ovf   <= 1'b1;
      if (w_tx_load)        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_tx_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // TX FSM: serialises one popped byte per frame, each bit CLKS_PER_BIT cycles.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      uart_txd   <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else if (w_tx_load) begin
      r_tx_state <= TX_START;
      r_tx_cnt   <= '0;
      r_tx_shift <= r_fifo[r_rd_ptr];
      uart_txd   <= 1'b0;
`ifdef UART_PARITY_EN
      r_tx_par   <= f_even_par(r_fifo[r_rd_ptr]);
`endif
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_tx_cnt <= '0;
          uart_txd <= 1'b1;
        end
        TX_START: begin
          if (r_tx_cnt == C_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            uart_txd   <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == C_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              uart_txd   <= r_tx_par;
              r_tx_state <= TX_PARITY;
`else
              uart_txd   <= 1'b1;
              r_tx_state <= TX_STOP;
`endif
            end else begin
              uart_txd   <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_bit   <= r_tx_bit + 1'b1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (r_tx_cnt == C_LAST) begin
            r_tx_cnt   <= '0;
            uart_txd   <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (r_tx_cnt == C_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: begin
          r_tx_state <= TX_IDLE;
          r_tx_cnt   <= '0;
          uart_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_xcvr.sv
`timescale 1ns/1ps
module tb_uart_byte_xcvr;

  localparam int CPB = 10;
`ifdef UART_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       uart_rxd;
  logic       uart_txd;
  logic       uart_rec;
  logic [7:0] uart_data_out;
  logic       uart_send;
  logic [7:0] uart_data_in;
  logic       tx_busy;
  logic       tx_full;
  logic       rx_err;
  logic       tx_ovf;

  uart_byte_xcvr #(
    .CLK_FREQ(50_000_000), .BAUD(5_000_000), .REC_PULSE(2), .TX_FIFO_DEPTH(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .uart_rec(uart_rec), .uart_data_out(uart_data_out), .uart_send(uart_send),
    .uart_data_in(uart_data_in), .tx_busy(tx_busy), .tx_full(tx_full),
    .rx_err(rx_err), .tx_ovf(tx_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- output monitors (sampled on falling edge) ----------------
  int         rec_rises = 0, err_rises = 0, run_rec = 0, run_err = 0;
  logic [7:0] rec_data_q[$];
  int         rec_len_q[$];
  int         err_len_q[$];

  initial begin : rx_out_monitor
    forever begin
      @(negedge sys_clk);
      if (uart_rec === 1'b1) begin
        if (run_rec == 0) begin
          rec_rises++;
          rec_data_q.push_back(uart_data_out);
        end
        run_rec++;
      end else if (run_rec != 0) begin
        rec_len_q.push_back(run_rec);
        run_rec = 0;
      end
      if (rx_err === 1'b1) begin
        if (run_err == 0) err_rises++;
        run_err++;
      end else if (run_err != 0) begin
        err_len_q.push_back(run_err);
        run_err = 0;
      end
    end
  end

  // Reference UART receiver decoding uart_txd at mid-bit.
  logic [7:0] tx_q[$];
  logic       tx_ok_q[$];
  int         tx_starts[$];
  logic       dec_busy = 1'b0;
`ifdef UART_PARITY_EN
  logic       tx_par_q[$];
  logic       rx_par_flip = 1'b0;
`endif

  initial begin : tx_decoder
    logic [7:0] d;
    logic       ok;
    forever begin
      @(negedge sys_clk);
      if (uart_txd === 1'b0 && sys_rst === 1'b0) begin
        dec_busy = 1'b1;
        tx_starts.push_back(cyc);
        ok = 1'b1;
        repeat (CPB/2) @(negedge sys_clk);
        if (uart_txd !== 1'b0) ok = 1'b0;
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge sys_clk);
          d[b] = uart_txd;
        end
`ifdef UART_PARITY_EN
        repeat (CPB) @(negedge sys_clk);
        tx_par_q.push_back(uart_txd);
        if (uart_txd !== ^d) ok = 1'b0;
`endif
        repeat (CPB) @(negedge sys_clk);
        if (uart_txd !== 1'b1) ok = 1'b0;
        tx_q.push_back(d);
        tx_ok_q.push_back(ok);
        dec_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rx_frame(input logic [7:0] d, input logic stop);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int b = 0; b < 8; b++) begin
      uart_rxd = d[b];
      repeat (CPB) @(negedge sys_clk);
    end
`ifdef UART_PARITY_EN
    uart_rxd = (^d) ^ rx_par_flip;
    repeat (CPB) @(negedge sys_clk);
`endif
    uart_rxd = stop;
    repeat (CPB) @(negedge sys_clk);
    uart_rxd = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    uart_data_in = d;
    uart_send    = 1'b1;
    @(negedge sys_clk);
    uart_send    = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic wait_tx_idle(input int limit, input string name);
    int n = 0;
    while ((tx_busy !== 1'b0 || dec_busy) && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    check(name, (n < limit), 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_rec;
    int         exp_err;
  } rx_vec_t;

  rx_vec_t    rx_vecs[6];
  logic [7:0] exp_q[$];
  logic [7:0] rb;
  logic       good;
  int         r0, e0, exp_err, lows, n_push;

  initial begin
    rx_vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    rx_vecs[1] = '{8'h55, 1'b0, 8'hA5, 0, 1};
    rx_vecs[2] = '{8'h00, 1'b1, 8'h00, 1, 0};
    rx_vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    rx_vecs[4] = '{8'h81, 1'b0, 8'hFF, 0, 1};
    rx_vecs[5] = '{8'h3C, 1'b1, 8'h3C, 1, 0};

    sys_rst = 1'b1; uart_rxd = 1'b1; uart_send = 1'b0; uart_data_in = 8'h00;
    repeat (3) @(negedge sys_clk);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_rec", uart_rec, 1'b0);
    check("rst_data", uart_data_out, 8'h00);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_full", tx_full, 1'b0);
    check("rst_err", rx_err, 1'b0);
    check("rst_ovf", tx_ovf, 1'b0);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    // RX vector table
    for (int i = 0; i < 6; i++) begin
      r0 = rec_rises; e0 = err_rises;
      rx_frame(rx_vecs[i].data, rx_vecs[i].stop);
      repeat (2*CPB) @(negedge sys_clk);
      check($sformatf("rx_vec%0d_data", i), uart_data_out, rx_vecs[i].exp_data);
      check($sformatf("rx_vec%0d_rec", i), rec_rises - r0, rx_vecs[i].exp_rec);
      check($sformatf("rx_vec%0d_err", i), err_rises - e0, rx_vecs[i].exp_err);
    end

    // Back-to-back frames with no idle gap
    rec_data_q.delete(); r0 = rec_rises;
    rx_frame(8'h3F, 1'b1);
    rx_frame(8'h44, 1'b1);
    repeat (2*CPB) @(negedge sys_clk);
    check("b2b_rec_count", rec_rises - r0, 2);
    check("b2b_first", rec_data_q.size() > 0 ? rec_data_q[0] : 8'h00, 8'h3F);
    check("b2b_second", rec_data_q.size() > 1 ? rec_data_q[1] : 8'h00, 8'h44);

    // Short low glitch on idle line
    r0 = rec_rises; e0 = err_rises;
    uart_rxd = 1'b0;
    repeat (3) @(negedge sys_clk);
    uart_rxd = 1'b1;
    repeat (3*CPB) @(negedge sys_clk);
    check("glitch_rec", rec_rises - r0, 0);
    check("glitch_err", err_rises - e0, 0);
    check("glitch_data", uart_data_out, 8'h44);

    // Pulse widths: uart_rec is REC_PULSE wide, rx_err a single cycle
    check("rec_len_count", rec_len_q.size(), rec_rises);
    foreach (rec_len_q[i]) check($sformatf("rec_len%0d", i), rec_len_q[i], 2);
    check("err_len_count", err_len_q.size(), err_rises);
    foreach (err_len_q[i]) check($sformatf("err_len%0d", i), err_len_q[i], 1);

    // Randomised RX against the reference expectation
    rec_data_q.delete(); exp_q.delete(); e0 = err_rises; exp_err = 0;
    for (int i = 0; i < 10; i++) begin
      rb   = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      rx_frame(rb, good);
      if (good) exp_q.push_back(rb);
      else      exp_err++;
      repeat (good ? $urandom_range(0, 12) : $urandom_range(10, 20)) @(negedge sys_clk);
    end
    repeat (2*CPB) @(negedge sys_clk);
    check("rand_rx_count", rec_data_q.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("rand_rx%0d", i), i < rec_data_q.size() ? rec_data_q[i] : 8'h00, exp_q[i]);
    check("rand_rx_err", err_rises - e0, exp_err);

    // Five sends while idle, then a sixth while full
    tx_q.delete(); tx_ok_q.delete(); tx_starts.delete();
    uart_data_in = 8'h01; uart_send = 1'b1;
    @(negedge sys_clk);
    check("tx_lat_1cyc", uart_txd, 1'b1);
    uart_send = 1'b0;
    @(negedge sys_clk);
    check("tx_lat_2cyc", uart_txd, 1'b0);
    for (int i = 2; i <= 5; i++) push_byte(8'(i));
    check("tx_full_set", tx_full, 1'b1);
    check("tx_ovf_before", tx_ovf, 1'b0);
    push_byte(8'h06);
    check("tx_ovf_set", tx_ovf, 1'b1);
    wait_tx_idle(6*FRAME + 50, "five_idle");
    check("five_count", tx_q.size(), 5);
    foreach (tx_q[i]) begin
      check($sformatf("five_byte%0d", i), tx_q[i], 8'(i + 1));
      check($sformatf("five_ok%0d", i), tx_ok_q[i], 1'b1);
    end
    for (int i = 0; i + 1 < tx_starts.size(); i++)
      check($sformatf("five_gap%0d", i), tx_starts[i+1] - tx_starts[i], FRAME);
    check("tx_ovf_sticky", tx_ovf, 1'b1);
    check("tx_full_clear", tx_full, 1'b0);

    // uart_send held high for 50 cycles enqueues one byte
    tx_q.delete(); tx_ok_q.delete();
    uart_data_in = 8'h5A; uart_send = 1'b1;
    repeat (50) @(negedge sys_clk);
    uart_send = 1'b0;
    wait_tx_idle(3*FRAME, "hold_idle");
    check("hold_count", tx_q.size(), 1);
    check("hold_byte", tx_q.size() > 0 ? tx_q[0] : 8'h00, 8'h5A);

    // Randomised TX bursts against a queue of pushed bytes
    for (int g = 0; g < 5; g++) begin
      tx_q.delete(); tx_ok_q.delete(); exp_q.delete();
      n_push = $urandom_range(1, 4);
      for (int k = 0; k < n_push; k++) begin
        rb = 8'($urandom_range(0, 255));
        push_byte(rb);
        exp_q.push_back(rb);
      end
      wait_tx_idle(n_push*(FRAME + 10) + 50, "rand_tx_idle");
      check($sformatf("rand_tx%0d_count", g), tx_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
        check($sformatf("rand_tx%0d_byte%0d", g, i), i < tx_q.size() ? tx_q[i] : 8'h00, exp_q[i]);
        check($sformatf("rand_tx%0d_ok%0d", g, i), i < tx_ok_q.size() ? tx_ok_q[i] : 1'b0, 1'b1);
      end
    end

`ifdef UART_PARITY_EN
    tx_q.delete(); tx_par_q.delete();
    push_byte(8'h07);
    wait_tx_idle(2*FRAME, "par_tx_idle");
    check("par_tx_byte", tx_q.size() > 0 ? tx_q[0] : 8'h00, 8'h07);
    check("par_tx_bit", tx_par_q.size() > 0 ? tx_par_q[0] : 1'b0, 1'b1);
    r0 = rec_rises; e0 = err_rises;
    rx_par_flip = 1'b1;
    rx_frame(8'h03, 1'b1);
    rx_par_flip = 1'b0;
    repeat (2*CPB) @(negedge sys_clk);
    check("par_rx_err", err_rises - e0, 1);
    check("par_rx_rec", rec_rises - r0, 0);
`endif

    // Reset in the middle of TX data bit 3 (bytes 0x00 keep the line low)
    push_byte(8'h00);
    push_byte(8'h00);
    repeat (43) @(negedge sys_clk);
    check("midtx_low", uart_txd, 1'b0);
    check("midtx_busy", tx_busy, 1'b1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midtx_rst_txd", uart_txd, 1'b1);
    check("midtx_rst_busy", tx_busy, 1'b0);
    check("midtx_rst_full", tx_full, 1'b0);
    check("midtx_rst_ovf", tx_ovf, 1'b0);
    sys_rst = 1'b0;
    lows = 0;
    repeat (3*FRAME) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("midtx_no_resume", lows, 0);
    check("midtx_idle_busy", tx_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
